// File: rtl/overlay_pkg.sv
// Shared definitions for the overlay frame sequencer.
//   ovl_state_e        : sequencer state encoding
//   TIMEOUT_CYCLES_DEF : default per-state wait limit before abort
//   CNT_W_DEF          : default completed-frame counter width
//   wait_width()       : counter width able to hold TIMEOUT_CYCLES-1
package overlay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_STOP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_ACK   = 3'd4
  } ovl_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;
  localparam int unsigned CNT_W_DEF          = 16;

  // Width of the per-state wait counter; never below one bit.
  function automatic int unsigned wait_width(input int unsigned limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clock, reset : clock / async active-low reset
//   req          : request levels
//   advance      : grant is being consumed this cycle; rotate priority
//   grant        : one-hot grant (combinational from req and priority)
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // High when requester 1 wins the next tie.
  logic prio_one;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_one ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Favor whichever requester was not granted last.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio_one <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      prio_one <= grant[0];
    end
  end

endmodule

// File: rtl/overlay_sequencer.sv
// Overlay frame sequencer: arbitrates two frame requesters and runs a
// start/done four-phase handshake with the overlay generator per frame.
//   clock, reset        : clock / async active-low reset
//   enable              : permits launching new frames
//   req, req_scroll     : per-requester request level and scroll select
//   ack                 : one-cycle completion pulse to the frame owner
//   ovl_start           : start level to the generator
//   ovl_start_ack       : start echo from the generator
//   ovl_done            : frame-done level from the generator
//   ovl_done_ack        : done acknowledge to the generator
//   ovl_scroll          : scroll select, frozen for the frame
//   busy                : any state other than IDLE
//   frame_count         : completed frames, wrapping
//   timeout, err        : abort pulse / sticky abort flag
//   err_clr             : clears err
module overlay_sequencer
  import overlay_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       req,
  input  logic [1:0]       req_scroll,
  output logic [1:0]       ack,
  output logic             ovl_start,
  input  logic             ovl_start_ack,
  input  logic             ovl_done,
  output logic             ovl_done_ack,
  output logic             ovl_scroll,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic             timeout,
  output logic             err,
  input  logic             err_clr
);

  localparam int unsigned       WAIT_W    = wait_width(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  ovl_state_e        state;
  ovl_state_e        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              owner;
  logic [1:0]        grant;
  logic              launch_c;
  logic              abort_c;
  logic              complete_c;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (launch_c),
    .grant   (grant)
  );

  // Next state; an expired wait in any handshake state wins over progress.
  always_comb begin
    state_nxt  = state;
    launch_c   = 1'b0;
    abort_c    = 1'b0;
    complete_c = 1'b0;
    if ((state != ST_IDLE) && (wait_cnt == WAIT_LAST)) begin
      abort_c   = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && (grant != 2'b00)) begin
            launch_c  = 1'b1;
            state_nxt = ST_START;
          end
        end
        ST_START: begin
          if (ovl_start_ack) state_nxt = ST_STOP;
        end
        ST_STOP: begin
          // A generator that finishes before dropping its echo skips RUN.
          if (ovl_done)           state_nxt = ST_ACK;
          else if (!ovl_start_ack) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (ovl_done) state_nxt = ST_ACK;
        end
        ST_ACK: begin
          if (!ovl_done) begin
            complete_c = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, wait counter and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      owner        <= 1'b0;
      ovl_start    <= 1'b0;
      ovl_done_ack <= 1'b0;
      ovl_scroll   <= 1'b0;
      busy         <= 1'b0;
      ack          <= 2'b00;
      frame_count  <= '0;
      timeout      <= 1'b0;
      err          <= 1'b0;
    end else begin
      state <= state_nxt;

      // Restart on every state entry; idle time is never counted.
      if ((state_nxt != state) || (state_nxt == ST_IDLE)) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      // Handshake levels follow the state one cycle late, except that an
      // abort drops them together with the return to IDLE.
      ovl_start    <= (state == ST_START) && !abort_c;
      ovl_done_ack <= (state == ST_ACK) && !abort_c;

      busy    <= (state_nxt != ST_IDLE);
      timeout <= abort_c;
      ack     <= complete_c ? (owner ? 2'b10 : 2'b01) : 2'b00;

      if (complete_c) begin
        frame_count <= frame_count + CNT_W'(1);
      end

      if (launch_c) begin
        owner      <= grant[1];
        ovl_scroll <= req_scroll[grant[1]];
      end

      // A new abort outranks a coincident clear.
      if (abort_c) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule
